// File: rtl/timer_int_if.sv
// Bus between the CPU datapath and the timer: register writes and
// interrupt acknowledge in, counter value and status out.
interface timer_int_if #(
  parameter int W = 8
);
  logic         we;
  logic         addr;
  logic [W-1:0] wdata;
  logic         ack;
  logic [W-1:0] count;
  logic         irq;
  logic         ovf;
  logic         running;

  // CPU side: drives register writes and the interrupt acknowledge
  modport master (
    output we, addr, wdata, ack,
    input  count, irq, ovf, running
  );

  // Timer side
  modport slave (
    input  we, addr, wdata, ack,
    output count, irq, ovf, running
  );
endinterface

// File: rtl/timer_int.sv
// Programmable down-counting timer with prescaler, auto-reload or
// one-shot mode, a sticky interrupt level and a missed-interrupt flag.
module timer_int #(
  parameter int W    = 8,
  parameter int PS_W = 7
) (
  input  logic       clk,
  input  logic       reset,
  timer_int_if.slave bus
);

  // The largest SEL that still fits the prescaler; larger values saturate
  localparam logic [2:0]      SEL_MAX = 3'((PS_W > 7) ? 7 : PS_W);
  localparam logic [PS_W:0]   ONE_WIDE = (PS_W + 1)'(1);

  logic [W-1:0]    reload_q, reload_d;
  logic [W-1:0]    count_q,  count_d;
  logic [PS_W-1:0] presc_q,  presc_d;
  logic            en_q,  en_d;
  logic            ar_q,  ar_d;
  logic [2:0]      sel_q, sel_d;
  logic            irq_q, irq_d;
  logic            ovf_q, ovf_d;

  logic            wr_reload;
  logic            wr_ctrl;
  logic [2:0]      sel_eff;
  logic [PS_W:0]   mask_wide;
  logic [PS_W-1:0] mask;
  logic            tick;
  logic            expiry;

  // Decode writes, derive the prescaler tick and the expiry event
  always_comb begin
    wr_reload = bus.we & ~bus.addr;
    wr_ctrl   = bus.we &  bus.addr;
    sel_eff   = (sel_q > SEL_MAX) ? SEL_MAX : sel_q;
    mask_wide = (ONE_WIDE << sel_eff) - ONE_WIDE;
    mask      = mask_wide[PS_W-1:0];
    tick      = en_q & ((presc_q & mask) == mask);
    expiry    = tick & (count_q == '0);
  end

  // Next-state logic: a register write wins over the tick for its own target
  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    presc_d  = presc_q;
    en_d     = en_q;
    ar_d     = ar_q;
    sel_d    = sel_q;
    irq_d    = irq_q;
    ovf_d    = ovf_q;

    // prescaler free-runs while enabled and restarts on any register write
    if (en_q) begin
      presc_d = presc_q + PS_W'(1);
    end else begin
      presc_d = '0;
    end

    // counter: decrement, or reload / stop on expiry
    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - W'(1);
      end else if (ar_q) begin
        count_d = reload_q;
      end else begin
        en_d = 1'b0;
      end
    end

    if (wr_reload) begin
      reload_d = bus.wdata;
      count_d  = bus.wdata;
      presc_d  = '0;
    end

    // reserved CTRL bits are simply not stored
    if (wr_ctrl) begin
      en_d    = bus.wdata[0];
      ar_d    = bus.wdata[1];
      sel_d   = bus.wdata[4:2];
      presc_d = '0;
    end

    // sticky interrupt and overflow; a fresh expiry beats the acknowledge
    if (expiry) begin
      irq_d = 1'b1;
      if (irq_q) begin
        ovf_d = 1'b1;
      end
    end else if (bus.ack) begin
      irq_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
      count_q  <= '0;
      presc_q  <= '0;
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      sel_q    <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      en_q     <= en_d;
      ar_q     <= ar_d;
      sel_q    <= sel_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.irq     = irq_q;
  assign bus.ovf     = ovf_q;
  assign bus.running = en_q;

endmodule

// File: tb/tb_timer_int.sv
// Directed scoreboard bench for timer_int: each stimulus cycle queues the
// hand-computed outputs expected after its clock edge; a monitor pops and
// compares them on the following falling edge.
module tb_timer_int;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  timer_int_if #(.W(8)) bus ();

  timer_int #(.W(8), .PS_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] c;
    logic       i;
    logic       o;
    logic       r;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;

  // count rising edges so queued expectations can be matched to their edge
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(string name, string field, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  task automatic chk_all(string name, logic [7:0] c, logic i, logic o, logic r);
    chk(name, "count",   bus.count,          c);
    chk(name, "irq",     {7'd0, bus.irq},     {7'd0, i});
    chk(name, "ovf",     {7'd0, bus.ovf},     {7'd0, o});
    chk(name, "running", {7'd0, bus.running}, {7'd0, r});
  endtask

  // monitor: compare DUT outputs against every expectation due at this edge
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.cyc < edge_cnt) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d checked late at edge %0d",
                 e.name, e.cyc, edge_cnt);
      end else begin
        chk_all(e.name, e.c, e.i, e.o, e.r);
        $display("[edge %0d] %s count=%02h irq=%b ovf=%b run=%b",
                 edge_cnt, e.name, bus.count, bus.irq, bus.ovf, bus.running);
      end
    end
  end

  // one clock cycle of stimulus plus the outputs expected after its edge
  task automatic step(bit w, bit a, logic [7:0] d, bit k,
                      logic [7:0] c, bit i, bit o, bit r, string name);
    exp_t e;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.ack   = k;
    e.cyc  = edge_cnt + 1;
    e.c    = c;
    e.i    = i;
    e.o    = o;
    e.r    = r;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(logic [7:0] c, bit i, bit o, bit r, string name);
    step(1'b0, 1'b0, 8'h00, 1'b0, c, i, o, r, name);
  endtask

  task automatic ack(logic [7:0] c, bit i, bit o, bit r, string name);
    step(1'b0, 1'b0, 8'h00, 1'b1, c, i, o, r, name);
  endtask

  task automatic wr(bit a, logic [7:0] d, logic [7:0] c, bit i, bit o, bit r, string name);
    step(1'b1, a, d, 1'b0, c, i, o, r, name);
  endtask

  // global time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.we    = 1'b0;
    bus.addr  = 1'b0;
    bus.wdata = 8'h00;
    bus.ack   = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk_all("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // periodic mode, RELOAD=3, SEL=0
    wr(1'b0, 8'h03, 8'h03, 0, 0, 0, "per_reload");
    wr(1'b1, 8'h03, 8'h03, 0, 0, 1, "per_ctrl");
    idle(8'h02, 0, 0, 1, "per_cnt2");
    idle(8'h01, 0, 0, 1, "per_cnt1");
    idle(8'h00, 0, 0, 1, "per_cnt0");
    idle(8'h03, 1, 0, 1, "per_expire1");
    idle(8'h02, 1, 0, 1, "per_cnt2b");
    idle(8'h01, 1, 0, 1, "per_cnt1b");
    idle(8'h00, 1, 0, 1, "per_cnt0b");
    idle(8'h03, 1, 1, 1, "per_expire2_ovf");
    ack(8'h02, 0, 0, 1, "per_ack");
    wr(1'b1, 8'h00, 8'h01, 0, 0, 0, "per_disable");

    // prescale by 4, RELOAD=1
    wr(1'b0, 8'h01, 8'h01, 0, 0, 0, "ps_reload");
    wr(1'b1, 8'h0B, 8'h01, 0, 0, 1, "ps_ctrl");
    idle(8'h01, 0, 0, 1, "ps_wait1");
    idle(8'h01, 0, 0, 1, "ps_wait2");
    idle(8'h01, 0, 0, 1, "ps_wait3");
    idle(8'h00, 0, 0, 1, "ps_tick1");
    idle(8'h00, 0, 0, 1, "ps_wait5");
    idle(8'h00, 0, 0, 1, "ps_wait6");
    idle(8'h00, 0, 0, 1, "ps_wait7");
    idle(8'h01, 1, 0, 1, "ps_expire");
    ack(8'h01, 0, 0, 1, "ps_ack");
    wr(1'b1, 8'h00, 8'h01, 0, 0, 0, "ps_disable");

    // one-shot, RELOAD=2
    wr(1'b0, 8'h02, 8'h02, 0, 0, 0, "os_reload");
    wr(1'b1, 8'h01, 8'h02, 0, 0, 1, "os_ctrl");
    idle(8'h01, 0, 0, 1, "os_cnt1");
    idle(8'h00, 0, 0, 1, "os_cnt0");
    idle(8'h00, 1, 0, 0, "os_expire");
    for (int n = 0; n < 20; n++) idle(8'h00, 1, 0, 0, "os_hold");
    ack(8'h00, 0, 0, 0, "os_ack");

    // ack / overflow with RELOAD=0
    wr(1'b0, 8'h00, 8'h00, 0, 0, 0, "ov_reload");
    wr(1'b1, 8'h03, 8'h00, 0, 0, 1, "ov_ctrl");
    idle(8'h00, 1, 0, 1, "ov_exp1");
    idle(8'h00, 1, 1, 1, "ov_exp2_ovf");
    ack(8'h00, 1, 1, 1, "ov_ack_on_expiry");
    wr(1'b1, 8'h07, 8'h00, 1, 1, 1, "ov_sel1");
    ack(8'h00, 0, 0, 1, "ov_ack_no_expiry");
    idle(8'h00, 1, 0, 1, "ov_exp3");
    idle(8'h00, 1, 0, 1, "ov_gap");
    idle(8'h00, 1, 1, 1, "ov_exp4_ovf");
    ack(8'h00, 0, 0, 1, "ov_ack2");
    wr(1'b1, 8'h00, 8'h00, 1, 0, 0, "ov_disable_expire");
    ack(8'h00, 0, 0, 0, "ov_ack3");

    // RELOAD write on the expiry edge
    wr(1'b0, 8'h02, 8'h02, 0, 0, 0, "col_reload");
    wr(1'b1, 8'h03, 8'h02, 0, 0, 1, "col_ctrl");
    idle(8'h01, 0, 0, 1, "col_cnt1");
    idle(8'h00, 0, 0, 1, "col_cnt0");
    wr(1'b0, 8'h50, 8'h50, 1, 0, 1, "col_write_wins");
    idle(8'h4F, 1, 0, 1, "col_after");

    // asynchronous reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    $display("[async] async_reset count=%02h irq=%b ovf=%b run=%b",
             bus.count, bus.irq, bus.ovf, bus.running);
    @(negedge clk);
    idle(8'h00, 0, 0, 0, "rst_hold1");
    wr(1'b0, 8'h20, 8'h00, 0, 0, 0, "rst_write_ignored");
    reset = 1'b1;
    idle(8'h00, 0, 0, 0, "rst_released");
    idle(8'h00, 0, 0, 0, "rst_idle");
    wr(1'b0, 8'h01, 8'h01, 0, 0, 0, "re_reload");
    wr(1'b1, 8'h03, 8'h01, 0, 0, 1, "re_ctrl");
    idle(8'h00, 0, 0, 1, "re_cnt0");
    idle(8'h01, 1, 0, 1, "re_expire");

    // let the monitor drain, bounded
    for (int n = 0; n < 5 && sb_q.size() > 0; n++) @(negedge clk);
    if (sb_q.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked", sb_q.size());
      errors += sb_q.size();
      checks += sb_q.size();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_int.md
Name: timer_int

Overview:
- Programmable 8-bit down-counting timer peripheral for the single-cycle I/O CPU.
- Programmed from one of the datapath's output-port registers (port data plus write strobe).
- Its count is read back through an input port, and its irq output drives one of the datapath's intPortN interrupt lines.
- Its ack input is connected to the control unit's finInterrup.

Parameters:
- W, 8, counter/reload/data width.
- PS_W, 7, prescaler counter width; the maximum division is 2^PS_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  write strobe (one cycle per write).
- addr  in  1  register select: 0 = RELOAD, 1 = CTRL.
- wdata  in  W  write data from the output-port register.
- ack  in  1  interrupt acknowledge (finInterrup).
- count  out  W  current counter value, to an input port.
- irq  out  1  interrupt request level, to intPortN.
- ovf  out  1  missed-interrupt flag.
- running  out  1  CTRL.EN.

Behaviour:
- Reset (reset=0, asynchronous): RELOAD=0, CTRL=0, count=0, presc=0, irq=0, ovf=0, running=0.
- CTRL bit fields:
  - [0] EN
  - [1] AR (auto-reload)
  - [4:2] SEL (prescale select)
  - [7:5] reserved; write-ignored, read as 0 internally.
- Write latency: all writes take effect at the clock edge where we=1; new values are visible the next cycle.
- Write RELOAD (we=1, addr=0): RELOAD<=wdata, count<=wdata, presc<=0.
- Write CTRL (we=1, addr=1): CTRL<=wdata, presc<=0. count is untouched.
- Prescaler:
  - Active only when EN=1; presc increments every cycle.
  - mask = (1<<SEL)-1.
  - tick = EN & ((presc & mask) == mask).
  - SEL=0 gives a tick every cycle; SEL=k gives a tick every 2^k cycles. SEL is limited to PS_W.
  - When EN=0, presc is held at 0.
- Counter, evaluated on a tick:
  - count!=0: count<=count-1.
  - count==0: expiry.
    - AR=1: count<=RELOAD.
    - AR=0 (one-shot): count stays 0 and EN<=0.
  - Period = (RELOAD+1) ticks. RELOAD=0 with AR=1 expires on every tick.
- irq: sticky level.
  - Set on expiry.
  - Cleared at the edge where ack=1.
  - Expiry and ack in the same cycle: irq stays 1 (set wins).
- ovf:
  - Set on an expiry while irq is already 1.
  - Cleared by ack.
  - Set wins over ack in the same cycle.
- Write versus tick in the same cycle: the write wins for its target register.
  - A RELOAD write overrides that cycle's count update.
  - A CTRL write overrides the one-shot EN clear.
  - An expiry in that cycle still sets irq.
- Arithmetic: count decrement is modulo-free, since 0 never decrements (it is handled as expiry). No signed arithmetic.
- running = CTRL.EN at all times.
- Reset mid-count: immediate return to reset values; irq drops asynchronously.
- Implementation constraints:
  - All state is registered; outputs come directly from registers, no combinational paths from inputs.
  - Exactly one clock domain.

Test Plan:
- Reset, then periodic mode:
  - Stimulus: write RELOAD=3; then CTRL=0x03 (EN, AR, SEL=0).
  - Required: count reads 3,2,1,0. irq rises on the 4th clock edge after the CTRL write edge, and count returns to 3 on that same edge. The next expiry comes 4 cycles later.
- Prescale:
  - Stimulus: RELOAD=1, CTRL=0x0B (EN, AR, SEL=2).
  - Required: count changes only every 4 cycles; irq first asserts 8 cycles after the CTRL write.
- One-shot:
  - Stimulus: RELOAD=2, CTRL=0x01.
  - Required: irq asserts after 3 ticks, and on that same edge running drops to 0. count stays 0 with no further expiry for 20 cycles. ack then clears irq.
- Ack/overflow:
  - Stimulus: periodic mode with RELOAD=0, SEL=0; leave irq unacked for 2 cycles.
  - Required: ovf=1. Pulse ack on a cycle with no expiry: irq=0 and ovf=0 next cycle. Pulse ack on an expiry cycle: irq remains 1.
- Write collision:
  - Stimulus: write RELOAD=0x50 on the same edge count would expire.
  - Required: count=0x50 next cycle; irq=1.
- Async reset:
  - Stimulus: assert reset mid-count with irq=1, between clock edges.
  - Required: irq, count, running and ovf go to 0 immediately, without waiting for a clock edge, and stay 0 until reset is released and the timer is reprogrammed.
